// File: rtl/shift_add_multiplier.sv
// Sequential unsigned W x W shift-add multiplier.
// One partial product per clock through a W-bit adder whose carry is kept,
// giving a 2W-bit product after W RUN cycles with a start/busy/done handshake.
module shift_add_multiplier #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state;
    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] acc;
    logic [CW-1:0]  cnt;

    logic [W:0]     sum;
    logic [2*W-1:0] acc_next;

    // Add the gated multiplicand to the upper accumulator half, carry kept,
    // then shift right by one with the W+1-bit sum entering at the top.
    always_comb begin
        sum      = {1'b0, acc[2*W-1:W]} + {1'b0, (mplier[0] ? mcand : '0)};
        acc_next = {sum, acc[W-1:1]};
    end

    // Control FSM and datapath registers; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= S_RUN;
                        busy   <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        product <= acc_next;
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned W x W multiplier built around a W-bit add-with-carry datapath, one partial product per clock.
- Sits directly downstream of the operand/sum stage in the multiplier design. It consumes the same packed operand pair, a = low nibble and b = high nibble at the top level, and produces a registered 2W-bit product with start/busy/done handshake.
- It is the multi-cycle companion to the combinational adder: it exercises the adder repeatedly instead of in parallel like the array multiplier.

Parameters:
- W, 4, operand width in bits. Legal range 2..8. Product width is 2W. The iteration counter is clog2(W+1) bits.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a multiplication. Sampled only in IDLE or DONE.
- a  input  W  multiplicand, captured on the accepting edge.
- b  input  W  multiplier, captured on the accepting edge.
- product  output  2W  result register. Updated only on completion and held otherwise.
- busy  output  1  high while a multiplication is in progress.
- done  output  1  one-cycle pulse; product is valid and new in this cycle.

Behaviour:
- One clock domain. Reset is asynchronous and active-low; the clock and reset ports are named clk and rst_n.
- Reset (rst_n=0, any time, including mid-operation):
  - state=IDLE; product=0; busy=0; done=0.
  - Internal multiplicand, multiplier, accumulator and counter are all cleared.
  - Any in-flight operation is abandoned with no done pulse.
- States are IDLE, RUN and DONE. All outputs are registered and there is no combinational path from inputs to outputs.
- IDLE, start=0: remain in IDLE; outputs hold.
- IDLE, start=1 on edge k:
  - mcand<=a; mplier<=b; acc<=0; cnt<=0; state<=RUN; busy<=1.
- RUN, each edge:
  - sum[W:0] = acc[2W-1:W] + (mplier[0] ? mcand : 0). The sum is W+1 bits; the carry is kept.
  - acc <= {sum, acc[W-1:1]}, i.e. a right shift by one with the sum entering at the top.
  - mplier <= mplier>>1; cnt <= cnt+1.
  - On the edge where cnt==W-1: product<=the final shifted acc value; state<=DONE; busy<=0; done<=1.
- Latency: with start accepted on edge k, busy is high from k through k+W. Product is updated and done=1 immediately after edge k+W, for exactly one cycle.
- DONE, start=0: state<=IDLE; done<=0; product holds.
- DONE, start=1: accepted exactly as in IDLE. state<=RUN, busy<=1, done<=0. This gives back-to-back operation with a W+1 cycle throughput.
- start during RUN: ignored. Operands captured at acceptance are used and a/b changes in RUN have no effect.
- Width rules:
  - Unsigned only.
  - The maximum product (2^W-1)^2 fits in 2W bits with no overflow.
  - The carry out of the W-bit add is never dropped.
- Zero operands: the block still takes the full W cycles and then produces 0. There is no early termination.
- product holds its old value throughout RUN and changes only in the done cycle.

Test Plan:
- Reset, then start with a=15, b=15 (W=4) -> busy high for 4 cycles; done pulse in cycle 5; product=225 (0xE1) and holds afterwards.
- Start with a=7, b=9 and toggle a/b randomly during RUN -> product=63; start pulses during busy are ignored and give no extra done.
- Start with a=0, b=13, then a=13, b=0 -> each takes 4 busy cycles; product=0 both times; exactly one done per operation.
- Back-to-back: hold start=1 continuously with a=3, b=5, then change to a=12, b=11 when done asserts -> products 15 then 132, one done every 5 cycles.
- Assert rst_n=0 asynchronously mid-RUN (between clock edges) during 10x10 -> product, busy and done go to 0 immediately with no done pulse. A following start with a=2, b=6 gives product=12.
- Exhaustive sweep of all 256 (a,b) pairs for W=4, compared against a*b -> zero mismatches; latency is always 4 busy cycles plus a 1-cycle done.
